// File: rtl/vga_pkg.sv
// VGA 640x480@60 timing constants, phase encoding and colour helpers.
// Shared by the raster counters and the pixel output stage.
package vga_pkg;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;

  localparam int H_TOTAL = VGA_H_VISIBLE + VGA_H_FRONT
                         + VGA_H_SYNC + VGA_H_BACK;
  localparam int V_TOTAL = VGA_V_VISIBLE + VGA_V_FRONT
                         + VGA_V_SYNC + VGA_V_BACK;

  typedef enum logic [1:0] {
    VISIBLE,
    FRONT,
    SYNC,
    BACK
  } vga_phase_t;

  typedef logic [7:0] color_t;

  localparam color_t COLOR_BLACK  = 8'h00;
  localparam color_t COLOR_YELLOW = 8'hFC;

  function automatic vga_phase_t next_phase(vga_phase_t p);
    vga_phase_t n;
    n = VISIBLE;
    unique case (p)
      VISIBLE: n = FRONT;
      FRONT:   n = SYNC;
      SYNC:    n = BACK;
      BACK:    n = VISIBLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus VISIBLE/FRONT/SYNC/BACK phase FSM.
// Advances only when adv is high; wrap flags the last count of the axis.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int VIS_LEN   = 640,
  parameter int FRONT_LEN = 16,
  parameter int SYNC_LEN  = 96,
  parameter int BACK_LEN  = 48
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       adv,
  output logic [9:0] count,
  output vga_phase_t phase,
  output logic       wrap
);

  localparam int TOTAL = VIS_LEN + FRONT_LEN
                       + SYNC_LEN + BACK_LEN;

  logic [9:0] pcnt;
  logic [9:0] plen;

  always_comb begin
    plen = 10'(VIS_LEN);
    unique case (phase)
      VISIBLE: plen = 10'(VIS_LEN);
      FRONT:   plen = 10'(FRONT_LEN);
      SYNC:    plen = 10'(SYNC_LEN);
      BACK:    plen = 10'(BACK_LEN);
    endcase
  end

  assign wrap = adv && (count == 10'(TOTAL - 1));

  // Phase lengths sum to TOTAL, so the FSM re-enters VISIBLE on wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      pcnt  <= '0;
      phase <= VISIBLE;
    end else if (adv) begin
      count <= wrap ? '0 : count + 10'd1;
      if (pcnt == plen - 10'd1) begin
        pcnt  <= '0;
        phase <= next_phase(phase);
      end else begin
        pcnt <= pcnt + 10'd1;
      end
    end
  end

endmodule

// File: rtl/vga_controller.sv
// VGA raster generator: pixel divider, H/V axis counters, registered
// DAC/sync pins one pixel behind xpos/ypos, and a frame_start pulse.
module vga_controller
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK
) (
  input  logic       clk,
  input  logic       rst_n,
  input  color_t     color,
  output logic [8:0] xpos,
  output logic [8:0] ypos,
  output logic       active,
  output logic [2:0] vga_r,
  output logic [2:0] vga_g,
  output logic [1:0] vga_b,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       frame_start
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div;
  logic          pix_tick;
  logic [9:0]    hcount;
  logic [9:0]    vcount;
  vga_phase_t    hphase;
  vga_phase_t    vphase;
  logic          h_wrap;
  logic          unused_v_wrap;

  assign pix_tick = (div == DW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else begin
      div <= pix_tick ? '0 : div + DW'(1);
    end
  end

  vga_axis_counter #(
    .VIS_LEN   (H_VISIBLE),
    .FRONT_LEN (H_FRONT),
    .SYNC_LEN  (H_SYNC),
    .BACK_LEN  (H_BACK)
  ) u_h (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (pix_tick),
    .count (hcount),
    .phase (hphase),
    .wrap  (h_wrap)
  );

  vga_axis_counter #(
    .VIS_LEN   (V_VISIBLE),
    .FRONT_LEN (V_FRONT),
    .SYNC_LEN  (V_SYNC),
    .BACK_LEN  (V_BACK)
  ) u_v (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (h_wrap),
    .count (vcount),
    .phase (vphase),
    .wrap  (unused_v_wrap)
  );

  assign xpos   = hcount[9:1];
  assign ypos   = vcount[9:1];
  assign active = (hcount < 10'(H_VISIBLE))
               && (vcount < 10'(V_VISIBLE));

  // Pins sample the current pixel at its closing tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      hsync_n     <= 1'b1;
      vsync_n     <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= h_wrap
                  && (vcount == 10'(V_VISIBLE - 1));
      if (pix_tick) begin
        {vga_r, vga_g, vga_b} <= active ? color : COLOR_BLACK;
        hsync_n <= (hphase != SYNC);
        vsync_n <= (vphase != SYNC);
      end
    end
  end

endmodule

// File: tb/tb_vga_controller.sv
// Bench: full-size instance for line timing and colour pass, plus a
// shrunk-timing instance checked every clk against an arithmetic model.
module tb_vga_controller;

  localparam int CD = 2;
  localparam int HV = 16, HF = 4, HS = 6, HB = 6;
  localparam int VV = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic cmode = 1'b0;
  int   n = 0;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  logic [7:0] color_b, color_s;
  logic [8:0] xpos_b, ypos_b, xpos_s, ypos_s;
  logic       active_b, active_s;
  logic [2:0] r_b, g_b, r_s, g_s;
  logic [1:0] b_b, b_s;
  logic       hs_b, vs_b, fs_b, hs_s, vs_s, fs_s;

  vga_controller u_big (
    .clk         (clk),
    .rst_n       (rst_n),
    .color       (color_b),
    .xpos        (xpos_b),
    .ypos        (ypos_b),
    .active      (active_b),
    .vga_r       (r_b),
    .vga_g       (g_b),
    .vga_b       (b_b),
    .hsync_n     (hs_b),
    .vsync_n     (vs_b),
    .frame_start (fs_b)
  );

  vga_controller #(
    .CLK_DIV (CD),
    .H_VISIBLE (HV), .H_FRONT (HF),
    .H_SYNC    (HS), .H_BACK  (HB),
    .V_VISIBLE (VV), .V_FRONT (VF),
    .V_SYNC    (VS), .V_BACK  (VB)
  ) u_small (
    .clk         (clk),
    .rst_n       (rst_n),
    .color       (color_s),
    .xpos        (xpos_s),
    .ypos        (ypos_s),
    .active      (active_s),
    .vga_r       (r_s),
    .vga_g       (g_s),
    .vga_b       (b_s),
    .hsync_n     (hs_s),
    .vsync_n     (vs_s),
    .frame_start (fs_s)
  );

  function automatic logic [7:0] colf(int x, int y);
    return 8'((x * 37 + y * 11 + 5) & 255);
  endfunction

  assign color_s = cmode ? 8'hFF
                 : colf(int'(xpos_s), int'(ypos_s));
  assign color_b = (xpos_b == 9'd10 && ypos_b == 9'd5) ? 8'hFC
                 : (xpos_b == 9'd10 && ypos_b == 9'd6) ? 8'h03
                 : 8'h00;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n <= 0;
    else n <= n + 1;
  end

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at t=%0t",
               name, act, exp, $time);
    end
  endtask

  localparam logic [29:0] RST_VEC =
    {9'd0, 9'd0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};

  // Expected small-instance outputs k clks after reset release.
  function automatic logic [29:0] model(int k, logic cm);
    int p, h, v, q, hq, vq;
    logic [7:0] rgb;
    logic hs, vs, fs, act;
    p   = k / CD;
    h   = p % HT;
    v   = (p / HT) % VT;
    act = (h < HV) && (v < VV);
    rgb = 8'h00;
    hs  = 1'b1;
    vs  = 1'b1;
    if (p > 0) begin
      q  = p - 1;
      hq = q % HT;
      vq = (q / HT) % VT;
      if (hq < HV && vq < VV)
        rgb = cm ? 8'hFF : colf(hq / 2, vq / 2);
      hs = !(hq >= HV + HF && hq < HV + HF + HS);
      vs = !(vq >= VV + VF && vq < VV + VF + VS);
    end
    fs = (k > 0) && (k % CD == 0) && h == 0 && v == VV;
    return {9'(h / 2), 9'(v / 2), act, rgb, hs, vs, fs};
  endfunction

  logic [29:0] got_s;
  assign got_s = {xpos_s, ypos_s, active_s, r_s, g_s, b_s,
                  hs_s, vs_s, fs_s};

  always @(negedge clk) begin
    if (!rst_n) chk("small_rst", 32'(got_s), 32'(RST_VEC));
    else chk("small_model", 32'(got_s), 32'(model(n, cmode)));
  end

  int   fs_log[$];
  int   hs_fall[$], hs_rise[$], vs_fall[$], vs_rise[$];
  logic hs_p = 1'b1, vs_p = 1'b1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (fs_s) fs_log.push_back(n);
      if (hs_p && !hs_s) hs_fall.push_back(n);
      if (!hs_p && hs_s) hs_rise.push_back(n);
      if (vs_p && !vs_s) vs_fall.push_back(n);
      if (!vs_p && vs_s) vs_rise.push_back(n);
    end
    hs_p = hs_s;
    vs_p = vs_s;
  end

  task automatic wait_n(int t);
    int g;
    g = 0;
    while (n < t && g < 100000) begin
      @(negedge clk);
      g++;
    end
    chk("wait_n", 32'(n), 32'(t));
  endtask

  task automatic clear_logs();
    fs_log.delete();
    hs_fall.delete();
    hs_rise.delete();
    vs_fall.delete();
    vs_rise.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g, t_fall, t_rise;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("big_rst", 32'({xpos_b, ypos_b, active_b, r_b, g_b, b_b,
                        hs_b, vs_b, fs_b}), 32'(RST_VEC));
    clear_logs();
    @(negedge clk);
    #2 rst_n = 1'b1;

    wait_n(3);
    chk("xpos_e3", 32'(xpos_b), 32'd0);
    wait_n(4);
    chk("xpos_e4", 32'(xpos_b), 32'd1);

    g = 0;
    while (hs_b && g < 4000) begin @(negedge clk); g++; end
    t_fall = n;
    chk("hs_fall_1314", 32'(t_fall), 32'd1314);
    g = 0;
    while (!hs_b && g < 4000) begin @(negedge clk); g++; end
    t_rise = n;
    chk("hs_low_192", 32'(t_rise - t_fall), 32'd192);
    g = 0;
    while (hs_b && g < 4000) begin @(negedge clk); g++; end
    chk("line_1600", 32'(n - t_fall), 32'd1600);

    wait_n((10 * 800 + 20) * 2);
    chk("rgb_pre", 32'({r_b, g_b, b_b}), 32'h00);
    wait_n((10 * 800 + 21) * 2);
    chk("rgb_fc", 32'({r_b, g_b, b_b}), 32'hFC);
    chk("r7g7b0", 32'({r_b, g_b, 1'b0, b_b}), 32'({3'd7, 3'd7, 3'd0}));
    wait_n((12 * 800 + 21) * 2);
    chk("rgb_03", 32'({r_b, g_b, b_b}), 32'h03);

    chk("fs_count", 32'(fs_log.size()), 32'd16);
    if (fs_log.size() >= 2) begin
      chk("fs_first", 32'(fs_log[0]), 32'd768);
      chk("fs_period", 32'(fs_log[1] - fs_log[0]), 32'd1216);
    end
    if (hs_fall.size() > 0 && hs_rise.size() > 0) begin
      chk("s_hs_fall", 32'(hs_fall[0]), 32'd42);
      chk("s_hs_w", 32'(hs_rise[0] - hs_fall[0]), 32'd12);
    end else chk("s_hs_seen", 32'(hs_fall.size()), 32'd1);
    if (vs_fall.size() > 0 && vs_rise.size() > 0) begin
      chk("s_vs_fall", 32'(vs_fall[0]), 32'd898);
      chk("s_vs_w", 32'(vs_rise[0] - vs_fall[0]), 32'd128);
    end else chk("s_vs_seen", 32'(vs_fall.size()), 32'd1);

    // Reset while the small instance's hsync pulse is low.
    g = 0;
    while (((n / CD) % (HT * VT)) != 7 * HT + 22 && g < 3000) begin
      @(negedge clk);
      g++;
    end
    chk("mid_pos", 32'((n / CD) % (HT * VT)), 32'(7 * HT + 22));
    chk("mid_hs_low", 32'(hs_s), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst", 32'(got_s), 32'(RST_VEC));
    cmode = 1'b1;
    repeat (3) @(negedge clk);
    clear_logs();
    #2 rst_n = 1'b1;

    wait_n(4);
    chk("blank_vis", 32'({r_s, g_s, b_s}), 32'hFF);
    wait_n(2 * (HV + 1));
    chk("blank_hfp", 32'({r_s, g_s, b_s}), 32'h00);
    wait_n(2500);
    chk("fs2_count", 32'(fs_log.size()), 32'd2);
    if (fs_log.size() > 0)
      chk("fs2_first", 32'(fs_log[0]), 32'd768);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
